// File: rtl/rf_bypass_if.sv
// Read/write port bundle for the 8x16 register file.
// The master drives the selects and write data, and the slave returns the bypassed read data.
interface rf_bypass_if;
    logic [2:0]  read1RegSel;
    logic [2:0]  read2RegSel;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        write;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic        err;

    modport master (
        output read1RegSel, read2RegSel, writeRegSel, writeData, write,
        input  read1Data, read2Data, err
    );

    modport slave (
        input  read1RegSel, read2RegSel, writeRegSel, writeData, write,
        output read1Data, read2Data, err
    );
endinterface

// File: rtl/rf_bypass.sv
// 8x16 register file: two combinational read ports, one synchronous write port, write-to-read bypass.
// A per-register valid bit flags reads of registers that have not been written since reset.
module rf_bypass (
    input logic        clk,
    input logic        rst,
    rf_bypass_if.slave bus
);
    logic [7:0][15:0] regs_q, regs_d;
    logic [7:0]       valid_q, valid_d;

    logic [15:0] raw1, raw2;
    logic        bypass1, bypass2;

    always_comb begin
        regs_d  = regs_q;
        valid_d = valid_q;
        if (bus.write) begin
            regs_d[bus.writeRegSel]  = bus.writeData;
            valid_d[bus.writeRegSel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q  <= '0;
            valid_q <= '0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
        end
    end

    // The bypass stays live during reset: a matching write is forwarded even though it is not stored.
    always_comb begin
        raw1    = regs_q[bus.read1RegSel];
        raw2    = regs_q[bus.read2RegSel];
        bypass1 = bus.write && (bus.writeRegSel == bus.read1RegSel);
        bypass2 = bus.write && (bus.writeRegSel == bus.read2RegSel);
        bus.read1Data = bypass1 ? bus.writeData : raw1;
        bus.read2Data = bypass2 ? bus.writeData : raw2;
        bus.err = (!valid_q[bus.read1RegSel] && !bypass1) ||
                  (!valid_q[bus.read2RegSel] && !bypass2);
    end
endmodule

// File: tb/tb_rf_bypass.sv
// Directed bench for rf_bypass: a reference model pushes expected reads to a scoreboard,
// and the bench pops and compares them against the DUT at mid-cycle.
module tb_rf_bypass;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_bypass_if bus ();
    rf_bypass dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       tag;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_reg[8];
    logic        m_val[8];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    function automatic exp_t predict(input string tag);
        exp_t x;
        logic b1, b2;
        b1    = bus.write && (bus.writeRegSel == bus.read1RegSel);
        b2    = bus.write && (bus.writeRegSel == bus.read2RegSel);
        x.tag = tag;
        x.d1  = b1 ? bus.writeData : m_reg[bus.read1RegSel];
        x.d2  = b2 ? bus.writeData : m_reg[bus.read2RegSel];
        x.e   = (!m_val[bus.read1RegSel] && !b1) || (!m_val[bus.read2RegSel] && !b2);
        return x;
    endfunction

    task automatic check();
        exp_t x;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty got 0 entries exp 1");
            return;
        end
        x = sb.pop_front();
        vectors++;
        assert (bus.read1Data === x.d1) else begin
            miscompares++;
            $error("FAIL %s read1Data got %h exp %h", x.tag, bus.read1Data, x.d1);
        end
        vectors++;
        assert (bus.read2Data === x.d2) else begin
            miscompares++;
            $error("FAIL %s read2Data got %h exp %h", x.tag, bus.read2Data, x.d2);
        end
        vectors++;
        assert (bus.err === x.e) else begin
            miscompares++;
            $error("FAIL %s err got %b exp %b", x.tag, bus.err, x.e);
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, and optionally cross the next rising edge.
    task automatic step(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] ws,
                        input logic [15:0] wd, input logic we, input logic r,
                        input string tag, input bit take_edge);
        rst             = r;
        bus.read1RegSel = s1;
        bus.read2RegSel = s2;
        bus.writeRegSel = ws;
        bus.writeData   = wd;
        bus.write       = we;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i] = 16'h0000;
                m_val[i] = 1'b0;
            end
        end
        sb.push_back(predict(tag));
        #2;
        check();
        if (take_edge) begin
            @(posedge clk);
            if (!rst && we) begin
                m_reg[ws] = wd;
                m_val[ws] = 1'b1;
            end
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 16'h0000;
            m_val[i] = 1'b0;
        end

        // reset and post-reset state
        step(3'd3, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b1, "rst_hold",    1'b1);
        step(3'd3, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b0, "reset_state", 1'b1);

        // write and read back
        step(3'd2, 3'd7, 3'd2, 16'hBEEF, 1'b1, 1'b0, "wr_r2",    1'b1);
        step(3'd2, 3'd7, 3'd7, 16'h1234, 1'b1, 1'b0, "wr_r7",    1'b1);
        step(3'd2, 3'd7, 3'd0, 16'h0000, 1'b0, 1'b0, "readback", 1'b1);

        // bypass on both ports
        step(3'd0, 3'd1, 3'd4, 16'h0001, 1'b1, 1'b0, "wr_r4",        1'b1);
        step(3'd4, 3'd4, 3'd4, 16'hA5A5, 1'b1, 1'b0, "bypass_both",  1'b1);
        step(3'd4, 3'd4, 3'd0, 16'h0000, 1'b0, 1'b0, "after_bypass", 1'b1);

        // non-matching concurrent write and read
        step(3'd0, 3'd2, 3'd6, 16'h0066, 1'b1, 1'b0, "wr_r6",     1'b1);
        step(3'd6, 3'd2, 3'd1, 16'hFFFF, 1'b1, 1'b0, "nonmatch",  1'b1);
        step(3'd1, 3'd6, 3'd0, 16'h0000, 1'b0, 1'b0, "read_r1",   1'b1);

        // sweep: write every register, then read every pair
        for (int i = 0; i < 8; i++)
            step(3'(i), 3'(7 - i), 3'(i), 16'(16'h1111 * i), 1'b1, 1'b0, "sweep_wr", 1'b1);
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                step(3'(a), 3'(b), 3'd0, 16'h0000, 1'b0, 1'b0, "sweep_rd", 1'b1);

        // async reset pulse between edges, then a write held during reset
        step(3'd0, 3'd7, 3'd0, 16'h0000, 1'b0, 1'b1, "async_rst",       1'b0);
        step(3'd3, 3'd5, 3'd3, 16'hDEAD, 1'b1, 1'b1, "rst_write",       1'b1);
        step(3'd3, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b0, "after_rst_write", 1'b1);

        // first edge after deassertion commits
        step(3'd3, 3'd3, 3'd3, 16'h7777, 1'b1, 1'b0, "first_wr",   1'b1);
        step(3'd3, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b0, "first_read", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
